bitstream_writer: RTL and testbench

Serializes a parallel word of `NUM_BITS_TO_WRITE` bits onto a 1-bit AXI-stream master, LSB first, one bit per accepted beat. It is the transmit-side counterpart of the bitstream reader. It is used for configuration readback and for feeding chained fabric blocks from a locally held word. The final beat carries `tlast`.

---
 rtl/bitstream_writer_pkg.sv | 18 +
 rtl/axi_stream_if.sv | 12 +
 rtl/bitstream_writer.sv | 160 ++++++++++++++++
 tb/tb_bitstream_writer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/bitstream_writer_pkg.sv
// Shared types and helpers for the bitstream writer (and its reader counterpart).
package bitstream_writer_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    SEND_BIT    = 3'd1,
    SEND_PARITY = 3'd2,
    DONE        = 3'd3
  } t_bitstream_writer_state;

  // Counter width for an n-bit frame: max(1, clog2(n)).
  function automatic int unsigned stream_cnt_width(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w < 32'd1) ? 32'd1 : w;
  endfunction

endpackage

// File: rtl/axi_stream_if.sv
// Minimal AXI-stream bundle shared by stream producers and consumers.
interface axi_stream_if #(
  parameter int DATA_W = 1
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/bitstream_writer.sv
// Serializes a captured parallel word LSB-first onto a 1-bit AXI-stream master.
// Optional trailing even-parity beat when BITSTREAM_WRITER_PARITY_EN is defined.
module bitstream_writer
  import bitstream_writer_pkg::*;
#(
  parameter int NUM_BITS_TO_WRITE = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [NUM_BITS_TO_WRITE-1:0] bits,
  axi_stream_if.master                 bitstream,
  output logic                         busy,
  output logic                         done
);

  localparam int unsigned CNT_W = stream_cnt_width(NUM_BITS_TO_WRITE);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BITS_TO_WRITE - 1);
`ifdef BITSTREAM_WRITER_PARITY_EN
  localparam logic LAST_ON_DATA = 1'b0;
`else
  localparam logic LAST_ON_DATA = 1'b1;
`endif

  t_bitstream_writer_state        state_q, state_d;
  logic [NUM_BITS_TO_WRITE-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic                           tvalid_q, tvalid_d;
  logic                           tdata_q, tdata_d;
  logic                           tlast_q, tlast_d;
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;
`ifdef BITSTREAM_WRITER_PARITY_EN
  logic                           parity_q, parity_d;
`endif

  // Next-state and next-output logic; stream outputs are computed one cycle ahead and registered.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef BITSTREAM_WRITER_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SEND_BIT;
          shift_d  = bits;
          cnt_d    = '0;
          tvalid_d = 1'b1;
          tdata_d  = bits[0];
          tlast_d  = LAST_ON_DATA && (LAST_CNT == '0);
          busy_d   = 1'b1;
`ifdef BITSTREAM_WRITER_PARITY_EN
          parity_d = ^bits;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      SEND_BIT: begin
        if (tvalid_q && bitstream.tready) begin
          shift_d = shift_q >> 1;
          // Terminal beat: the counter is left in place so it can never wrap.
          if (cnt_q == LAST_CNT) begin
`ifdef BITSTREAM_WRITER_PARITY_EN
            state_d = SEND_PARITY;
            tdata_d = parity_q;
            tlast_d = 1'b1;
`else
            state_d  = DONE;
            tvalid_d = 1'b0;
            tdata_d  = 1'b0;
            tlast_d  = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
`endif
          end else begin
            cnt_d   = cnt_q + 1'b1;
            tdata_d = shift_d[0];
            tlast_d = LAST_ON_DATA && (cnt_d == LAST_CNT);
          end
        end else begin
          state_d = SEND_BIT;
        end
      end
`ifdef BITSTREAM_WRITER_PARITY_EN
      SEND_PARITY: begin
        if (tvalid_q && bitstream.tready) begin
          state_d  = DONE;
          tvalid_d = 1'b0;
          tdata_d  = 1'b0;
          tlast_d  = 1'b0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end else begin
          state_d = SEND_PARITY;
        end
      end
`endif
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        tvalid_d = 1'b0;
        tdata_d  = 1'b0;
        tlast_d  = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= 1'b0;
      tlast_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

`ifdef BITSTREAM_WRITER_PARITY_EN
  // Even parity of the captured word, sent as the trailing beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  assign bitstream.tvalid = tvalid_q;
  assign bitstream.tdata  = tdata_q;
  assign bitstream.tlast  = tlast_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule

// File: tb/tb_bitstream_writer.sv
// Directed, table-driven bench for bitstream_writer (N=8 and N=1 instances).
// Honors BITSTREAM_WRITER_PARITY_EN to expect the extra parity beat.
module tb_bitstream_writer;

`ifdef BITSTREAM_WRITER_PARITY_EN
  localparam int FRAME8 = 9;
  localparam bit PAR    = 1'b1;
`else
  localparam int FRAME8 = 8;
  localparam bit PAR    = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8, start1;
  logic [7:0] bits8;
  logic [0:0] bits1;
  logic       busy8, done8, busy1, done1;

  axi_stream_if #(.DATA_W(1)) s8 ();
  axi_stream_if #(.DATA_W(1)) s1 ();

  bitstream_writer #(.NUM_BITS_TO_WRITE(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .bits(bits8),
    .bitstream(s8), .busy(busy8), .done(done8)
  );

  bitstream_writer #(.NUM_BITS_TO_WRITE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .bits(bits1),
    .bitstream(s1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  int acc8 = 0, last8 = 0, acc1 = 0, last1 = 0;
  int n_vec = 0, n_err = 0;

  // Count accepted beats and accepted tlast beats on both streams.
  always @(posedge clk) begin
    if (s8.tvalid && s8.tready) begin
      acc8 <= acc8 + 1;
      if (s8.tlast) last8 <= last8 + 1;
    end
    if (s1.tvalid && s1.tready) begin
      acc1 <= acc1 + 1;
      if (s1.tlast) last1 <= last1 + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [7:0] bits;
    logic [7:0] exp_word;
    logic       exp_par;
    int         stall_a;
    int         stall_b;
    int         stall_len;
  } vec_t;

  vec_t vecs[5];

  task automatic start_frame(input logic [7:0] b);
    start8 = 1'b1;
    bits8  = b;
    @(posedge clk); #1;
    chk("e0_tvalid", 32'(s8.tvalid), 32'd1);
    chk("e0_busy", 32'(busy8), 32'd1);
    start8 = 1'b0;
    bits8  = ~b;
  endtask

  // Runs every beat of an already-started frame, then checks the done cycle.
  task automatic send_beats(input logic [7:0] w, input logic par,
                            input int sa, input int sb, input int slen);
    int a0, l0;
    logic [7:0] rec;
    logic exp_bit;
    a0 = acc8;
    l0 = last8;
    rec = 8'h00;
    s8.tready = 1'b1;
    for (int k = 0; k < FRAME8; k++) begin
      exp_bit = (k < 8) ? w[k] : par;
      if (k == sa || k == sb) begin
        s8.tready = 1'b0;
        for (int s = 0; s < slen; s++) begin
          chk("stall_tvalid", 32'(s8.tvalid), 32'd1);
          chk("stall_tdata", 32'(s8.tdata), 32'(exp_bit));
          chk("stall_tlast", 32'(s8.tlast), 32'(k == FRAME8 - 1));
          @(posedge clk); #1;
        end
        s8.tready = 1'b1;
      end
      chk("beat_tvalid", 32'(s8.tvalid), 32'd1);
      chk("beat_tdata", 32'(s8.tdata), 32'(exp_bit));
      chk("beat_tlast", 32'(s8.tlast), 32'(k == FRAME8 - 1));
      chk("beat_busy", 32'(busy8), 32'd1);
      if (k < 8) rec[k] = s8.tdata;
      bits8 = 8'($urandom);
      @(posedge clk); #1;
    end
    chk("recovered", 32'(rec), 32'(w));
    chk("done_pulse", 32'(done8), 32'd1);
    chk("end_tvalid", 32'(s8.tvalid), 32'd0);
    chk("end_busy", 32'(busy8), 32'd0);
    chk("accepts", 32'(acc8 - a0), 32'(FRAME8));
    chk("tlast_accepts", 32'(last8 - l0), 32'd1);
  endtask

  initial begin
    int a0, l0;
    rst_n = 1'b0;
    start8 = 1'b0; start1 = 1'b0;
    bits8 = 8'h00; bits1 = 1'b0;
    s8.tready = 1'b0; s1.tready = 1'b0;

    vecs[0] = '{bits: 8'hA5, exp_word: 8'hA5, exp_par: 1'b0, stall_a: -1, stall_b: -1, stall_len: 0};
    vecs[1] = '{bits: 8'h3C, exp_word: 8'h3C, exp_par: 1'b0, stall_a: 1,  stall_b: 6,  stall_len: 3};
    vecs[2] = '{bits: 8'h07, exp_word: 8'h07, exp_par: 1'b1, stall_a: -1, stall_b: -1, stall_len: 0};
    vecs[3] = '{bits: 8'h80, exp_word: 8'h80, exp_par: 1'b1, stall_a: FRAME8 - 1, stall_b: -1, stall_len: 1};
    vecs[4] = '{bits: 8'h00, exp_word: 8'h00, exp_par: 1'b0, stall_a: 0,  stall_b: -1, stall_len: 2};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_tvalid", 32'(s8.tvalid), 32'd0);
    chk("rst_tdata", 32'(s8.tdata), 32'd0);
    chk("rst_tlast", 32'(s8.tlast), 32'd0);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 5; v++) begin
      start_frame(vecs[v].bits);
      send_beats(vecs[v].exp_word, vecs[v].exp_par, vecs[v].stall_a, vecs[v].stall_b, vecs[v].stall_len);
      @(posedge clk); #1;
      chk("done_once", 32'(done8), 32'd0);
      chk("idle_tvalid", 32'(s8.tvalid), 32'd0);
    end

    // start held high and bits scrambled mid-frame: one frame, restart at EN+2.
    start8 = 1'b1;
    bits8  = 8'h5A;
    @(posedge clk); #1;
    chk("hold_e0_tvalid", 32'(s8.tvalid), 32'd1);
    send_beats(8'h5A, 1'b0, -1, -1, 0);
    bits8 = 8'hC3;
    @(posedge clk); #1;
    chk("hold_en1_tvalid", 32'(s8.tvalid), 32'd0);
    chk("hold_en1_done", 32'(done8), 32'd0);
    @(posedge clk); #1;
    chk("hold_en2_tvalid", 32'(s8.tvalid), 32'd1);
    chk("hold_en2_busy", 32'(busy8), 32'd1);
    start8 = 1'b0;
    send_beats(8'hC3, 1'b0, -1, -1, 0);
    @(posedge clk); #1;

    // Reset after beat 4 aborts the frame without done or tlast.
    start_frame(8'hA5);
    a0 = acc8;
    l0 = last8;
    s8.tready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_tvalid", 32'(s8.tvalid), 32'd0);
    chk("abort_busy", 32'(busy8), 32'd0);
    chk("abort_done", 32'(done8), 32'd0);
    chk("abort_accepts", 32'(acc8 - a0), 32'd4);
    @(negedge clk);
    chk("abort_no_tlast", 32'(last8 - l0), 32'd0);
    chk("abort_hold_done", 32'(done8), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    start_frame(8'h3C);
    send_beats(8'h3C, 1'b0, -1, -1, 0);
    @(posedge clk); #1;

    // Single-bit frame.
    s1.tready = 1'b1;
    start1 = 1'b1;
    bits1  = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    bits1  = 1'b0;
    chk("n1_tvalid", 32'(s1.tvalid), 32'd1);
    chk("n1_tdata", 32'(s1.tdata), 32'd1);
    chk("n1_tlast", 32'(s1.tlast), 32'(!PAR));
    @(posedge clk); #1;
    if (PAR) begin
      chk("n1_par_tdata", 32'(s1.tdata), 32'd1);
      chk("n1_par_tlast", 32'(s1.tlast), 32'd1);
      @(posedge clk); #1;
    end
    chk("n1_done", 32'(done1), 32'd1);
    chk("n1_end_tvalid", 32'(s1.tvalid), 32'd0);
    chk("n1_accepts", 32'(acc1), 32'(PAR ? 2 : 1));
    chk("n1_tlast_accepts", 32'(last1), 32'd1);
    @(posedge clk); #1;
    chk("n1_done_once", 32'(done1), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
